aes_dec_sequencer: RTL and testbench
====================================

AES_DEC_SEQUENCER -- requirements
Module: aes_dec_sequencer

Interface
REQ-001 SHALL have port Clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1: ciphertext_in is offered.
REQ-004 SHALL have port in_ready, output, 1: sequencer accepts a block; high only in IDLE.
REQ-005 SHALL have port ciphertext_in, input, [0:127]: block to decrypt, MSB-first byte order.
REQ-006 SHALL have port key_idx, output, 4: round-key index requested from external key store, 0..10.
REQ-007 SHALL have port round_key, input, [0:127]: key for key_idx, valid combinationally in the same cycle.
REQ-008 SHALL have port dp_in, output, [0:127]: state fed to the shared inverse-round datapath (AddRoundKey, InvMixColumns, InvShiftRows, InvSubBytes, in that order).
REQ-009 SHALL have port dp_mix_en, output, 1: datapath applies InvMixColumns when high and bypasses it when low.
REQ-010 SHALL have port dp_result, input, [0:127]: combinational datapath output for dp_in/round_key/dp_mix_en.
REQ-011 SHALL have port out_valid, output, 1: plaintext_out is valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts plaintext_out.
REQ-013 SHALL have port plaintext_out, output, [0:127]: decrypted block, registered.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, INIT, ROUND, FINAL, DONE, with a 4-bit round counter rnd and a 128-bit state register st.
REQ-016 SHALL, in IDLE with in_valid=1, load st<=ciphertext_in and go to INIT; the handshake cycle is T.
REQ-017 SHALL, in INIT (T+1), drive key_idx=10, dp_mix_en=0, dp_in=st, load st<=dp_result, set rnd<=9, and go to ROUND.
REQ-018 SHALL, in ROUND (T+2..T+10), drive key_idx=rnd, dp_mix_en=1, dp_in=st, load st<=dp_result, decrement rnd, and go to FINAL after the cycle with rnd=1.
REQ-019 SHALL, in FINAL (T+11), drive key_idx=0, load plaintext_out<=st XOR round_key internally without the datapath, and go to DONE.
REQ-020 SHALL assert out_valid in DONE, first at T+12, and hold plaintext_out stable until out_ready=1.
REQ-021 SHALL, in DONE with out_ready=1, return to IDLE; the next block is accepted no earlier than the following cycle, giving a minimum of 13 cycles per block.
REQ-022 SHALL ignore in_valid outside IDLE; ciphertext_in is sampled only at the handshake.
REQ-023 SHALL drive dp_mix_en=0 and key_idx=0 in IDLE, FINAL and DONE; dp_in SHALL equal st in all states.
REQ-024 SHALL never present key_idx above 10.

Reset
REQ-025 SHALL, on Reset=1 at any time including mid-operation, immediately force IDLE, rnd=0, st=0, plaintext_out=0, out_valid=0, busy=0, in_ready=0.
REQ-026 SHALL assert in_ready=1 from the first Clk edge after Reset deasserts; a block in flight when Reset asserts SHALL be discarded.

Configuration
REQ-027 SHALL, when macro AES_DEC_SEQ_ABORT_EN is defined, add input abort (1 bit): abort=1 in INIT, ROUND, FINAL or DONE returns to IDLE on the next edge, clears out_valid, and produces no output; abort in IDLE SHALL have no effect; abort has priority over the out_ready handshake.
REQ-028 SHALL, without AES_DEC_SEQ_ABORT_EN, have no abort port, and every accepted block SHALL run to DONE.

Verification
REQ-029 SHALL pass FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext_out 00112233445566778899aabbccddeeff with out_valid at T+12; key_idx sequence 10,9,...,1,0; dp_mix_en pattern 0, then 1 x9.
REQ-030 SHALL pass backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid and plaintext_out held, in_ready=0 throughout, and the second block accepted only after the DONE handshake.
REQ-031 SHALL pass back-to-back: in_valid held high with 3 blocks and out_ready=1 -> handshakes exactly 13 cycles apart and 3 correct outputs in order.
REQ-032 SHALL pass reset mid-operation: Reset at T+6 -> all outputs are reset values in the same cycle, no out_valid, and a fresh C.1 block afterwards decrypts correctly.
REQ-033 SHALL pass, with AES_DEC_SEQ_ABORT_EN: abort at T+5 -> IDLE at T+6, in_ready=1, no out_valid; abort pulsed in IDLE -> no effect.

Source files
------------

// File: rtl/aes_dec_sequencer_if.sv
// Handshake, key-store and shared inverse-round datapath signals of aes_dec_sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface aes_dec_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] ciphertext_in;
  logic [3:0]   key_idx;
  logic [0:127] round_key;
  logic [0:127] dp_in;
  logic         dp_mix_en;
  logic [0:127] dp_result;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] plaintext_out;
  logic         busy;

  modport slave (
    input  in_valid, ciphertext_in, round_key, dp_result, out_ready,
    output in_ready, key_idx, dp_in, dp_mix_en, out_valid, plaintext_out, busy
  );

  modport master (
    output in_valid, ciphertext_in, round_key, dp_result, out_ready,
    input  in_ready, key_idx, dp_in, dp_mix_en, out_valid, plaintext_out, busy
  );
endinterface

// File: rtl/aes_dec_sequencer.sv
// AES-128 decryption round sequencer driving an external inverse-round datapath and key store.
// Optional abort input enabled by defining AES_DEC_SEQ_ABORT_EN.
module aes_dec_sequencer (
  input logic Clk,
  input logic Reset,
`ifdef AES_DEC_SEQ_ABORT_EN
  input logic abort,
`endif
  aes_dec_sequencer_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for a block; in_ready once out of reset
  // INIT  | first inverse round with key 10, no InvMixColumns
  // ROUND | rounds 9..1 through the datapath with InvMixColumns
  // FINAL | plaintext = st ^ key 0, datapath unused
  // DONE  | out_valid held until out_ready
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]   r_state;
  logic [3:0]   r_rnd;
  logic [0:127] r_st;
  logic [0:127] r_pt;
  logic         r_armed;
  logic         w_accept;
  logic         w_abort;

`ifdef AES_DEC_SEQ_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // r_armed keeps in_ready low until the first edge after reset release
  assign bus.in_ready      = (r_state == S_IDLE) && r_armed;
  assign w_accept          = bus.in_valid && bus.in_ready;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.out_valid     = (r_state == S_DONE);
  assign bus.dp_in         = r_st;
  assign bus.plaintext_out = r_pt;

  always_comb begin
    bus.key_idx   = 4'd0;
    bus.dp_mix_en = 1'b0;
    case (r_state)
      S_INIT:  bus.key_idx = 4'd10;
      S_ROUND: begin
        bus.key_idx   = r_rnd;
        bus.dp_mix_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_rnd   <= 4'd0;
      r_st    <= '0;
      r_pt    <= '0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_st    <= bus.ciphertext_in;
              r_state <= S_INIT;
            end
          end
          S_INIT: begin
            r_st    <= bus.dp_result;
            r_rnd   <= 4'd9;
            r_state <= S_ROUND;
          end
          S_ROUND: begin
            r_st  <= bus.dp_result;
            r_rnd <= r_rnd - 4'd1;
            if (r_rnd == 4'd1) r_state <= S_FINAL;
          end
          S_FINAL: begin
            r_pt    <= r_st ^ bus.round_key;
            r_state <= S_DONE;
          end
          S_DONE: begin
            if (bus.out_ready) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Directed bench for aes_dec_sequencer with a behavioural key store and inverse-round datapath.
// Abort scenarios are included when AES_DEC_SEQ_ABORT_EN is defined.
module tb_aes_dec_sequencer;
  logic Clk = 1'b0;
  logic Reset;
`ifdef AES_DEC_SEQ_ABORT_EN
  logic abort;
`endif

  aes_dec_sequencer_if bus();

  aes_dec_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
`ifdef AES_DEC_SEQ_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_B   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [0:127] CT_C   = 128'h0123456789abcdeffedcba9876543210;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int hs_cyc[$];
  int out_cyc[$];
  logic [0:127] out_pt[$];

  logic [7:0]   sbox [256];
  logic [7:0]   isbox[256];
  logic [0:127] rk   [11];
  logic         tables_ready = 1'b0;
  logic [0:127] b2b_ct [3];
  logic [0:127] b2b_exp[3];
  int t0, n0, hs0, ov0, hb, ob, k;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [0:127] inv_shift(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c-r+4)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] inv_sub(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = isbox[s[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [0:127] inv_mix(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
      o[32*c    +: 8] = gmul(a0,8'd14) ^ gmul(a1,8'd11) ^ gmul(a2,8'd13) ^ gmul(a3,8'd9);
      o[32*c+8  +: 8] = gmul(a0,8'd9)  ^ gmul(a1,8'd14) ^ gmul(a2,8'd11) ^ gmul(a3,8'd13);
      o[32*c+16 +: 8] = gmul(a0,8'd13) ^ gmul(a1,8'd9)  ^ gmul(a2,8'd14) ^ gmul(a3,8'd11);
      o[32*c+24 +: 8] = gmul(a0,8'd11) ^ gmul(a1,8'd13) ^ gmul(a2,8'd9)  ^ gmul(a3,8'd14);
    end
    return o;
  endfunction

  // External datapath: AddRoundKey, optional InvMixColumns, InvShiftRows, InvSubBytes
  function automatic logic [0:127] dp_model(input logic [0:127] s, input logic [0:127] key, input logic mix);
    logic [0:127] t;
    t = s ^ key;
    if (mix) t = inv_mix(t);
    return inv_sub(inv_shift(t));
  endfunction

  // Textbook inverse cipher, used for blocks without published plaintext
  function automatic logic [0:127] ref_dec(input logic [0:127] c);
    logic [0:127] s;
    s = c ^ rk[10];
    for (int r = 9; r >= 1; r--) begin
      s = inv_sub(inv_shift(s));
      s = inv_mix(s ^ rk[r]);
    end
    return inv_sub(inv_shift(s)) ^ rk[0];
  endfunction

  task automatic build_tables();
    logic [7:0]   inv, s, b, rc;
    logic [31:0]  w[44];
    logic [31:0]  t;
    logic [0:127] key;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; b = inv;
      for (int j = 0; j < 4; j++) begin
        b = {b[6:0], b[7]};
        s = s ^ b;
      end
      s = s ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
    key = C1_KEY;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    tables_ready = 1'b1;
  endtask

  always_comb begin
    bus.round_key = '0;
    if (tables_ready && bus.key_idx <= 4'd10) bus.round_key = rk[bus.key_idx];
  end

  always_comb begin
    bus.dp_result = '0;
    if (tables_ready) bus.dp_result = dp_model(bus.dp_in, bus.round_key, bus.dp_mix_en);
  end

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.in_valid && bus.in_ready) hs_cyc.push_back(cyc);
      if (bus.out_valid && bus.out_ready) begin
        out_cyc.push_back(cyc);
        out_pt.push_back(bus.plaintext_out);
      end
      if (bus.out_valid) ov_cnt++;
    end
  end

  // Caller sits just after a rising edge; returns just after the edge following the handshake
  task automatic send(input logic [0:127] c, input string tag);
    int n, w;
    n = hs_cyc.size(); w = 0;
    bus.ciphertext_in = c;
    bus.in_valid = 1'b1;
    while (hs_cyc.size() == n && w < 40) begin
      @(negedge Clk); #1;
      w++;
    end
    check({tag, "_handshake"}, 128'(hs_cyc.size() > n), 128'(1));
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    int w;
    w = 0;
    while (out_pt.size() <= n && w < 60) begin
      @(negedge Clk); #1;
      w++;
    end
    check({tag, "_out_seen"}, 128'(out_pt.size() > n), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.ciphertext_in = '0;
    bus.out_ready = 1'b0;
`ifdef AES_DEC_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    build_tables();
    b2b_ct[0] = C1_CT; b2b_ct[1] = CT_B; b2b_ct[2] = CT_C;
    b2b_exp[0] = C1_PT; b2b_exp[1] = ref_dec(CT_B); b2b_exp[2] = ref_dec(CT_C);

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_in_ready",  128'(bus.in_ready), 128'(0));
    check("rst_busy",      128'(bus.busy), 128'(0));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_plaintext", 128'(bus.plaintext_out), 128'(0));
    check("rst_key_idx",   128'(bus.key_idx), 128'(0));
    check("rst_mix_en",    128'(bus.dp_mix_en), 128'(0));
    check("rst_dp_in",     128'(bus.dp_in), 128'(0));
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    check("rel_ready_before_edge", 128'(bus.in_ready), 128'(0));
    @(negedge Clk);
    check("rel_ready_after_edge", 128'(bus.in_ready), 128'(1));

    // FIPS-197 C.1 with per-cycle key index and mix pattern
    @(posedge Clk); #1;
    bus.ciphertext_in = C1_CT;
    bus.in_valid = 1'b1;
    @(negedge Clk);
    check("c1_ready_at_T", 128'(bus.in_ready), 128'(1));
    t0 = cyc;
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    bus.ciphertext_in = ~C1_CT;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (i == 1) check("c1_dp_in_init", 128'(bus.dp_in), 128'(C1_CT));
      check($sformatf("c1_key_idx_T%0d", i), 128'(bus.key_idx),
            128'((i == 1) ? 10 : ((i <= 10) ? 11 - i : 0)));
      check($sformatf("c1_mix_T%0d", i), 128'(bus.dp_mix_en), 128'((i >= 2 && i <= 10) ? 1 : 0));
      check($sformatf("c1_busy_T%0d", i), 128'(bus.busy), 128'(1));
      check($sformatf("c1_out_valid_T%0d", i), 128'(bus.out_valid), 128'((i == 12) ? 1 : 0));
    end
    check("c1_plaintext", 128'(bus.plaintext_out), 128'(C1_PT));
    check("c1_latency", 128'(cyc - t0), 128'(12));

    // Backpressure: second block offered while first output is stalled
    @(posedge Clk); #1;
    bus.ciphertext_in = CT_B;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check($sformatf("bp_out_valid_%0d", i), 128'(bus.out_valid), 128'(1));
      check($sformatf("bp_pt_hold_%0d", i), 128'(bus.plaintext_out), 128'(C1_PT));
      check($sformatf("bp_in_ready_%0d", i), 128'(bus.in_ready), 128'(0));
    end
    n0 = out_pt.size(); hs0 = hs_cyc.size();
    @(posedge Clk); #1 bus.out_ready = 1'b1;
    @(negedge Clk); #1;
    check("bp_release_out", 128'(out_pt.size()), 128'(n0 + 1));
    check("bp_release_pt", 128'(out_pt[n0]), 128'(C1_PT));
    check("bp_no_accept_in_done", 128'(hs_cyc.size()), 128'(hs0));
    @(negedge Clk); #1;
    check("bp_second_accept", 128'(hs_cyc.size()), 128'(hs0 + 1));
    @(posedge Clk); #1 bus.in_valid = 1'b0;
    @(negedge Clk);
    check("bp_second_loaded", 128'(bus.dp_in), 128'(CT_B));
    wait_out(n0 + 1, "bp_second");
    check("bp_second_pt", 128'(out_pt[n0+1]), 128'(b2b_exp[1]));

    // Back-to-back: in_valid held high across three blocks
    repeat (2) @(posedge Clk);
    #1;
    hb = hs_cyc.size(); ob = out_pt.size();
    for (int b = 0; b < 3; b++) begin
      bus.ciphertext_in = b2b_ct[b];
      bus.in_valid = 1'b1;
      k = 0;
      while (hs_cyc.size() == hb + b && k < 40) begin
        @(negedge Clk); #1;
        k++;
      end
      check($sformatf("b2b_handshake_%0d", b), 128'(hs_cyc.size()), 128'(hb + b + 1));
      @(posedge Clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_out(ob + 2, "b2b");
    check("b2b_gap_01", 128'(hs_cyc[hb+1] - hs_cyc[hb]), 128'(13));
    check("b2b_gap_12", 128'(hs_cyc[hb+2] - hs_cyc[hb+1]), 128'(13));
    check("b2b_latency_0", 128'(out_cyc[ob] - hs_cyc[hb]), 128'(12));
    for (int b = 0; b < 3; b++)
      check($sformatf("b2b_pt_%0d", b), 128'(out_pt[ob+b]), 128'(b2b_exp[b]));

    // Reset in the middle of a block
    repeat (2) @(posedge Clk);
    #1;
    send(C1_CT, "rmid");
    repeat (5) @(posedge Clk);
    #1;
    check("rmid_busy_before", 128'(bus.busy), 128'(1));
    ov0 = ov_cnt; n0 = out_pt.size();
    Reset = 1'b1;
    #1;
    check("rmid_in_ready",  128'(bus.in_ready), 128'(0));
    check("rmid_busy",      128'(bus.busy), 128'(0));
    check("rmid_out_valid", 128'(bus.out_valid), 128'(0));
    check("rmid_plaintext", 128'(bus.plaintext_out), 128'(0));
    check("rmid_key_idx",   128'(bus.key_idx), 128'(0));
    check("rmid_mix_en",    128'(bus.dp_mix_en), 128'(0));
    check("rmid_dp_in",     128'(bus.dp_in), 128'(0));
    @(posedge Clk); #1 Reset = 1'b0;
    repeat (20) @(posedge Clk);
    #1;
    check("rmid_no_out_valid", 128'(ov_cnt), 128'(ov0));
    send(C1_CT, "rmid_fresh");
    wait_out(n0, "rmid_fresh");
    check("rmid_fresh_pt", 128'(out_pt[n0]), 128'(C1_PT));
    check("rmid_fresh_latency", 128'(out_cyc[n0] - hs_cyc[hs_cyc.size()-1]), 128'(12));

`ifdef AES_DEC_SEQ_ABORT_EN
    // Abort mid-block, then abort while idle
    repeat (2) @(posedge Clk);
    #1;
    ov0 = ov_cnt; n0 = out_pt.size();
    send(C1_CT, "abort");
    repeat (4) @(posedge Clk);
    #1 abort = 1'b1;
    @(posedge Clk); #1 abort = 1'b0;
    @(negedge Clk);
    check("abort_in_ready", 128'(bus.in_ready), 128'(1));
    check("abort_busy", 128'(bus.busy), 128'(0));
    repeat (15) @(posedge Clk);
    #1;
    check("abort_no_out_valid", 128'(ov_cnt), 128'(ov0));
    abort = 1'b1;
    @(negedge Clk);
    check("abort_idle_ready", 128'(bus.in_ready), 128'(1));
    @(posedge Clk); #1;
    bus.ciphertext_in = C1_CT;
    bus.in_valid = 1'b1;
    @(negedge Clk);
    check("abort_idle_accept_rdy", 128'(bus.in_ready), 128'(1));
    @(posedge Clk); #1;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge Clk);
    check("abort_idle_accepted", 128'(bus.busy), 128'(1));
    wait_out(n0, "abort_idle");
    check("abort_idle_pt", 128'(out_pt[n0]), 128'(C1_PT));
`endif

    repeat (2) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
